// File: rtl/bram_window_scanner.sv
// bram_window_scanner
//   Read sequencer for a single-port image BRAM with 1-cycle read latency.
//   Slides a WIN x WIN window over the image in raster order, issues one BRAM
//   read per tap and returns the taps as a valid/ready pixel stream tagged with
//   the window origin (or window centre when zero padding is enabled).
//
//   Optional build macro: ZERO_PAD_EN
//     defined   -> one window per image position (centred), out-of-bounds taps
//                  issue no read and stream out as 0.
//     undefined -> only fully in-bounds windows, no pad logic.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     start                 begin a full-image scan (sampled only in IDLE)
//     busy, done            scan in progress / one-cycle completion pulse
//     rd_v, rd_row, rd_col  BRAM read enable and row/column address
//     rd_data               BRAM read data, valid the cycle after rd_v
//     pix_valid, pix_ready  output stream handshake
//     pix_data              tap pixel
//     pix_win_last          tap is the last of its window
//     pix_last              tap is the last of the scan
//     win_row, win_col      window tag of the current tap
module bram_window_scanner #(
  parameter int IMG_H  = 12,
  parameter int IMG_W  = 12,
  parameter int WIN    = 3,
  parameter int STRIDE = 1,
  parameter int AW     = 4,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_v,
  output logic [AW-1:0] rd_row,
  output logic [AW-1:0] rd_col,
  input  logic [DW-1:0] rd_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [DW-1:0] pix_data,
  output logic          pix_win_last,
  output logic          pix_last,
  output logic [AW-1:0] win_row,
  output logic [AW-1:0] win_col
);

  // Origins are kept signed and two bits wider so that padded origins can go negative.
  localparam int CW = AW + 2;
`ifdef ZERO_PAD_EN
  localparam int HALF   = WIN / 2;
  localparam int ORG_LO = -(WIN / 2);
  localparam int ROW_HI = IMG_H - 1 - WIN / 2;
  localparam int COL_HI = IMG_W - 1 - WIN / 2;
`else
  localparam int HALF   = 0;
  localparam int ORG_LO = 0;
  localparam int ROW_HI = IMG_H - WIN;
  localparam int COL_HI = IMG_W - WIN;
`endif
  localparam logic signed [CW-1:0] ORG_MIN  = CW'(ORG_LO);
  localparam logic signed [CW-1:0] STEP     = CW'(STRIDE);
  // An origin above these limits is the last one of its row/column sweep.
  localparam logic signed [CW-1:0] ROW_LIM  = CW'(ROW_HI - STRIDE);
  localparam logic signed [CW-1:0] COL_LIM  = CW'(COL_HI - STRIDE);
  localparam logic [AW-1:0]        KMAX     = AW'(WIN - 1);
  localparam logic [AW-1:0]        HALF_A   = AW'(HALF);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [CW-1:0]   org_r_q, org_r_d, org_c_q, org_c_d;
  logic [AW-1:0]          ky_q, ky_d, kx_q, kx_d;
  logic [AW-1:0]          last_row_q, last_row_d, last_col_q, last_col_d;
  // One-slot read pipe: slot occupied plus the tag of the tap in flight.
  logic                   pend_q, pend_d, tag_oob_q, tag_oob_d;
  logic                   tag_wl_q, tag_wl_d, tag_last_q, tag_last_d;
  logic [AW-1:0]          tag_wr_q, tag_wr_d, tag_wc_q, tag_wc_d;
  // Two-entry output FIFO.
  logic [DW-1:0]          f_data_q [2], f_data_d [2];
  logic [AW-1:0]          f_wr_q [2], f_wr_d [2], f_wc_q [2], f_wc_d [2];
  logic                   f_wl_q [2], f_wl_d [2], f_last_q [2], f_last_d [2];
  logic                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]             cnt_q, cnt_d;

  logic          pop_s, issue_s, oob_s, win_last_s, scan_last_s;
  logic          last_kx_s, last_ky_s, last_oc_s, last_or_s;
  logic [1:0]    occ_s, cnt_after_pop_s;
  logic [AW-1:0] addr_r_s, addr_c_s;

  assign pop_s           = (cnt_q != 2'd0) && pix_ready;
  assign cnt_after_pop_s = cnt_q - {1'b0, pop_s};
  // Slots that will hold data after this cycle if no new read is issued.
  assign occ_s           = {1'b0, pend_q} + cnt_after_pop_s;
  assign issue_s         = (state_q == S_SCAN) && (occ_s <= 2'd1);

  assign last_kx_s   = (kx_q == KMAX);
  assign last_ky_s   = (ky_q == KMAX);
  assign last_oc_s   = (org_c_q > COL_LIM);
  assign last_or_s   = (org_r_q > ROW_LIM);
  assign win_last_s  = last_kx_s && last_ky_s;
  assign scan_last_s = win_last_s && last_oc_s && last_or_s;

  // Modulo-2^AW address arithmetic is exact for every in-bounds tap.
  assign addr_r_s = org_r_q[AW-1:0] + ky_q;
  assign addr_c_s = org_c_q[AW-1:0] + kx_q;

`ifdef ZERO_PAD_EN
  localparam logic signed [CW-1:0] ROWS_S = CW'(IMG_H);
  localparam logic signed [CW-1:0] COLS_S = CW'(IMG_W);
  logic signed [CW-1:0] tap_r_s, tap_c_s;
  assign tap_r_s = org_r_q + $signed({2'b00, ky_q});
  assign tap_c_s = org_c_q + $signed({2'b00, kx_q});
  assign oob_s   = tap_r_s[CW-1] || tap_c_s[CW-1] || (tap_r_s >= ROWS_S) || (tap_c_s >= COLS_S);
`else
  assign oob_s   = 1'b0;
`endif

  assign rd_v   = issue_s && !oob_s;
  assign rd_row = rd_v ? addr_r_s : last_row_q;
  assign rd_col = rd_v ? addr_c_s : last_col_q;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign pix_valid    = (cnt_q != 2'd0);
  assign pix_data     = f_data_q[rptr_q];
  assign pix_win_last = f_wl_q[rptr_q];
  assign pix_last     = f_last_q[rptr_q];
  assign win_row      = f_wr_q[rptr_q];
  assign win_col      = f_wc_q[rptr_q];

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (issue_s && scan_last_s) state_d = S_DRAIN;
      S_DRAIN: if (!pend_q && (cnt_after_pop_s == 2'd0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window/tap counters, held address and read-pipe tag.
  always_comb begin
    org_r_d    = org_r_q;
    org_c_d    = org_c_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    last_row_d = rd_v ? addr_r_s : last_row_q;
    last_col_d = rd_v ? addr_c_s : last_col_q;
    pend_d     = issue_s;
    tag_oob_d  = oob_s;
    tag_wl_d   = win_last_s;
    tag_last_d = scan_last_s;
    tag_wr_d   = org_r_q[AW-1:0] + HALF_A;
    tag_wc_d   = org_c_q[AW-1:0] + HALF_A;
    if (state_q == S_IDLE && start) begin
      org_r_d = ORG_MIN;
      org_c_d = ORG_MIN;
      ky_d    = '0;
      kx_d    = '0;
    end else if (issue_s) begin
      if (!last_kx_s) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (!last_ky_s) begin
          ky_d = ky_q + 1'b1;
        end else begin
          ky_d = '0;
          if (!last_oc_s) begin
            org_c_d = org_c_q + STEP;
          end else begin
            org_c_d = ORG_MIN;
            org_r_d = last_or_s ? ORG_MIN : (org_r_q + STEP);
          end
        end
      end
    end
  end

  // Output FIFO: push the returning read (or a padded zero), pop on handshake.
  always_comb begin
    f_data_d = f_data_q;
    f_wr_d   = f_wr_q;
    f_wc_d   = f_wc_q;
    f_wl_d   = f_wl_q;
    f_last_d = f_last_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_after_pop_s + {1'b0, pend_q};
    if (pend_q) begin
      f_data_d[wptr_q] = tag_oob_q ? '0 : rd_data;
      f_wr_d[wptr_q]   = tag_wr_q;
      f_wc_d[wptr_q]   = tag_wc_q;
      f_wl_d[wptr_q]   = tag_wl_q;
      f_last_d[wptr_q] = tag_last_q;
      wptr_d           = ~wptr_q;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = ~rptr_q;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      org_r_q    <= ORG_MIN;
      org_c_q    <= ORG_MIN;
      ky_q       <= '0;
      kx_q       <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      pend_q     <= 1'b0;
      tag_oob_q  <= 1'b0;
      tag_wl_q   <= 1'b0;
      tag_last_q <= 1'b0;
      tag_wr_q   <= '0;
      tag_wc_q   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data_q[i] <= '0;
        f_wr_q[i]   <= '0;
        f_wc_q[i]   <= '0;
        f_wl_q[i]   <= 1'b0;
        f_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      org_r_q    <= org_r_d;
      org_c_q    <= org_c_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      pend_q     <= pend_d;
      tag_oob_q  <= tag_oob_d;
      tag_wl_q   <= tag_wl_d;
      tag_last_q <= tag_last_d;
      tag_wr_q   <= tag_wr_d;
      tag_wc_q   <= tag_wc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      f_data_q   <= f_data_d;
      f_wr_q     <= f_wr_d;
      f_wc_q     <= f_wc_d;
      f_wl_q     <= f_wl_d;
      f_last_q   <= f_last_d;
    end
  end

endmodule

// File: tb/tb_bram_window_scanner.sv
// Self-checking bench for bram_window_scanner: a BRAM model, a reference
// pixel list built from nested loops over window origins and taps, and a
// table of scan scenarios (ready pattern, stray start, mid-scan reset).
module tb_bram_window_scanner;
  localparam int IMG_H = 12, IMG_W = 12, WIN = 3, STRIDE = 1, AW = 4, DW = 8;
`ifdef ZERO_PAD_EN
  localparam int HALF = WIN / 2;
  localparam bit PAD  = 1'b1;
`else
  localparam int HALF = 0;
  localparam bit PAD  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, busy, done, rd_v;
  logic [AW-1:0] rd_row, rd_col, win_row, win_col;
  logic [DW-1:0] rd_data, pix_data;
  logic          pix_valid, pix_ready, pix_win_last, pix_last;

  bram_window_scanner #(.IMG_H(IMG_H), .IMG_W(IMG_W), .WIN(WIN), .STRIDE(STRIDE), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_v(rd_v), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_win_last(pix_win_last), .pix_last(pix_last),
    .win_row(win_row), .win_col(win_col)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] img [IMG_H][IMG_W];

  // Single-port BRAM, one cycle read latency.
  always_ff @(posedge clk) begin
    if (rd_v) rd_data <= img[rd_row][rd_col];
  end

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] wr;
    logic [3:0] wc;
    logic       wl;
    logic       last;
  } pix_t;
  pix_t exp_q[$];

  typedef struct {
    int pct;
    int extra_start;
    int abort_at;
    int grab9;
    int exp_first;
    int exp_done;
    int exp_npix;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] win0 [9];
  int checks = 0, passes = 0;
  int n_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  function automatic void build_ref();
    int lo, hr, hc, rr, cc;
    pix_t p;
    lo = -HALF;
    hr = PAD ? IMG_H - 1 - HALF : IMG_H - WIN;
    hc = PAD ? IMG_W - 1 - HALF : IMG_W - WIN;
    for (int r = lo; r <= hr; r += STRIDE)
      for (int c = lo; c <= hc; c += STRIDE)
        for (int ky = 0; ky < WIN; ky++)
          for (int kx = 0; kx < WIN; kx++) begin
            rr = r + ky;
            cc = c + kx;
            p.d    = (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W) ? img[rr][cc] : 8'd0;
            p.wr   = 4'(r + HALF);
            p.wc   = 4'(c + HALF);
            p.wl   = (ky == WIN - 1) && (kx == WIN - 1);
            p.last = 1'b0;
            exp_q.push_back(p);
          end
    exp_q[exp_q.size() - 1].last = 1'b1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_v"}, 32'(rd_v), 32'd0);
    chk({tag, "_rd_row"}, 32'(rd_row), 32'd0);
    chk({tag, "_rd_col"}, 32'(rd_col), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_pix_win_last"}, 32'(pix_win_last), 32'd0);
    chk({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    chk({tag, "_win_row"}, 32'(win_row), 32'd0);
    chk({tag, "_win_col"}, 32'(win_col), 32'd0);
  endtask

  task automatic run_scan(input int pct, input int extra_start, input int abort_at, input int grab9,
                          output int first_v, output int done_c, output int npix,
                          output int max_fl, output bit rdv_abort);
    int cyc, issued;
    bit prev_stall, ended;
    logic [18:0] prev_v, cur_v;
    pix_t e;
    first_v = -1; done_c = -1; npix = 0; max_fl = 0; issued = 0;
    prev_stall = 1'b0; rdv_abort = 1'b0; ended = 1'b0; prev_v = '0;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    cyc = 0;
    while (cyc < 4000 && !ended) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_start);
      pix_ready = ($urandom_range(99) < pct);
      #1;
      cur_v = {pix_valid, pix_data, win_row, win_col, pix_win_last, pix_last};
      if (cyc == 1) chk("busy_cycle1", 32'(busy), 32'd1);
      if (prev_stall) chk("stall_hold", 32'(cur_v), 32'(prev_v));
      if (pix_valid && first_v < 0) first_v = cyc;
      if (rd_v) issued++;
      if (pix_valid && pix_ready) begin
        if (npix < exp_q.size()) begin
          e = exp_q[npix];
          chk($sformatf("pix%0d", npix), 32'(cur_v), 32'({1'b1, e}));
        end else begin
          chk("extra_pixel", 32'(npix), 32'(exp_q.size()));
        end
        if (grab9 != 0 && npix < 9) chk($sformatf("win0_tap%0d", npix), 32'(pix_data), 32'(win0[npix]));
        npix++;
      end
      if (issued - npix > max_fl) max_fl = issued - npix;
      prev_stall = pix_valid && !pix_ready;
      prev_v = cur_v;
      if (done) begin
        done_c = cyc;
        chk("pix_count_at_done", 32'(npix), 32'(exp_q.size()));
        ended = 1'b1;
      end
      if (cyc == abort_at) begin
        rdv_abort = rd_v;
        ended = 1'b1;
      end
    end
    chk("scan_terminated", 32'(ended), 32'd1);
  endtask

  initial begin
    int first_v, done_c, npix, max_fl;
    bit rdv_abort;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = 8'((r * 29 + c * 13 + 7) % 256);
    img[0][0] = 8'd3; img[0][1] = 8'd8;  img[0][2] = 8'd11;
    img[1][0] = 8'd4; img[1][1] = 8'd11; img[1][2] = 8'd14;
    img[2][0] = 8'd1; img[2][1] = 8'd3;  img[2][2] = 8'd4;
    build_ref();
    n_exp = exp_q.size();
`ifdef ZERO_PAD_EN
    win0 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd8, 8'd0, 8'd4, 8'd11};
`else
    win0 = '{8'd3, 8'd8, 8'd11, 8'd4, 8'd11, 8'd14, 8'd1, 8'd3, 8'd4};
`endif
    chk("ref_size", 32'(n_exp), PAD ? 32'd1296 : 32'd900);
    //          pct extra abort grab first done       npix
    vecs[0] = '{100, 0,   0,   1,   3,    n_exp + 3, n_exp};
    vecs[1] = '{50,  0,   0,   0,   -1,   -1,        n_exp};
    vecs[2] = '{100, 50,  0,   0,   3,    n_exp + 3, n_exp};
    vecs[3] = '{100, 0,   200, 0,   3,    -1,        198};
    vecs[4] = '{100, 0,   0,   1,   3,    n_exp + 3, n_exp};
    vecs[5] = '{100, 0,   0,   1,   3,    n_exp + 3, n_exp};

    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].pct, vecs[i].extra_start, vecs[i].abort_at, vecs[i].grab9,
               first_v, done_c, npix, max_fl, rdv_abort);
      if (vecs[i].exp_first >= 0) chk($sformatf("v%0d_first_valid", i), 32'(first_v), 32'(vecs[i].exp_first));
      if (vecs[i].exp_done >= 0) chk($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_npix", i), 32'(npix), 32'(vecs[i].exp_npix));
      chk($sformatf("v%0d_inflight_le2", i), 32'(max_fl <= 2), 32'd1);
      if (vecs[i].abort_at > 0) begin
        chk("rd_v_at_abort", 32'(rdv_abort), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #1;
          chk($sformatf("post_abort_valid%0d", k), 32'(pix_valid), 32'd0);
          chk($sformatf("post_abort_done%0d", k), 32'(done), 32'd0);
        end
      end
    end

    @(negedge clk);
    #1;
    chk("final_idle_busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
